locked_rr_arbiter: RTL
======================

# locked_rr_arbiter

- Shares one multi-cycle resource (a memory port, bus master or divider) among NUM_REQUESTERS clients.
- Round-robin arbitration issues a registered grant in both one-hot and binary-index form. The grant stays locked to the winner until that winner signals completion or a hold-limit timeout fires.
- Sits between the requesting units and the resource's mux select and control inputs.

## Interface

Parameters
- NUM_REQUESTERS, 4, number of clients; legal range 2..32.
- INDEX_WIDTH, `CLOG2(NUM_REQUESTERS), width of grant_idx.
- HOLD_LIMIT, 0, maximum cycles one grant may be held; 0 disables the timeout.

Ports
- clk  input  1  clock; everything is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  NUM_REQUESTERS  per-client request level.
- done  input  1  current owner finished; sampled only in BUSY.
- grant_valid  output  1  a grant is active.
- grant_oh  output  NUM_REQUESTERS  one-hot owner; all zero when grant_valid=0.
- grant_idx  output  INDEX_WIDTH  binary owner index; 0 when grant_valid=0.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation

- There are two states, IDLE and BUSY.
- IDLE, when any request bit is set:
  - Select the first set bit at or above priority pointer ptr, wrapping from NUM_REQUESTERS-1 back to 0.
  - Register grant_oh and grant_idx, set grant_valid and go to BUSY.
  - Set ptr = (winner+1) mod NUM_REQUESTERS.
- IDLE with no request: stay in IDLE; ptr is unchanged.
- BUSY with done=1: clear the grant, go to IDLE and clear the hold counter.
- BUSY with HOLD_LIMIT≠0 and the hold counter reaching HOLD_LIMIT-1 without done:
  - Clear the grant, pulse timeout for one cycle and go to IDLE.
  - If done and the limit hit occur in the same cycle, done wins and timeout stays 0.
- The owner dropping its request while BUSY has no effect; only done or timeout releases the grant.
- done asserted in IDLE is ignored.
- Request bits are not sampled in BUSY, so other clients cannot preempt the owner.
- The hold counter:
  - is ceil(log2(HOLD_LIMIT+1)) bits wide, with a minimum of 1;
  - starts at 0 on the grant cycle;
  - increments each BUSY cycle and saturates.
- When only one request is pending, it wins regardless of ptr.
- Invariants:
  - grant_oh is always zero or one-hot.
  - When grant_valid=1, grant_idx equals the position of the set bit in grant_oh.

## Timing

- Reset values: state=IDLE, ptr=0, grant_valid=0, grant_oh=0, grant_idx=0, timeout=0, hold counter=0.
- Grant latency: request seen in IDLE at cycle t gives grant_valid=1 at t+1.
- Release: done=1 in cycle t gives grant_valid=0 at t+1.
- The earliest next grant is at t+2, so there is one mandatory bubble cycle between owners.
- Timeout: grant at cycle g with no done releases at g+HOLD_LIMIT. At that edge grant_valid falls and timeout rises; timeout returns to 0 at the following cycle.
- Reset asserted mid-BUSY: all outputs return to reset values on the next edge, ptr returns to 0, and an in-progress grant is dropped silently with no timeout pulse.
- All outputs are registered; there is no combinational path from request or done to any output.

## Structure

- Shared package holds:
  - the state enum, typedef enum logic {IDLE, BUSY}, so that debug and trace logic can decode it;
  - the HOLD_LIMIT default constant.
- Sub-module rr_priority_select (combinational):
  - inputs: request and ptr;
  - outputs: next one-hot winner and its index.
  - Implementation: mask requests below ptr, take the lowest set bit of the masked vector, otherwise fall back to the lowest set bit of the raw vector.
  - Index conversion reuses the existing one-hot-to-index converter.
- The top level holds the state register, ptr, hold counter and output registers.

## Test plan

- Reset, then request=4'b0000 for 5 cycles:
  - expect grant_valid=0, grant_oh=0 and grant_idx=0 throughout.
- Fairness, request=4'b1111 held, done pulsed one cycle after each grant:
  - expect grant_idx sequence 0,1,2,3,0 with one idle cycle between grants.
- Wrap-around, ptr=3 after granting client 2, then request=4'b0011:
  - expect grant_idx=0, then 1 on the following grant.
- Lock: client 1 granted, request[1] drops and request[3] rises, done withheld 10 cycles (HOLD_LIMIT=0):
  - expect grant_idx=1 held for all 10 cycles;
  - expect grant_idx=3 two cycles after done.
- Timeout with HOLD_LIMIT=8, no done:
  - expect timeout=1 exactly 8 cycles after the grant, with grant_valid=0 in the same cycle.
  - Separately, done coinciding with the limit cycle: expect timeout=0.
- Reset asserted mid-BUSY with client 2 owning the grant:
  - expect all outputs zero on the next edge;
  - then request=4'b1111 gives grant_idx=0, because ptr was reset.

Source files
------------

// File: rtl/locked_rr_arbiter_pkg.sv
// Shared types, defaults and helpers for the locked round-robin arbiter.
package locked_rr_arbiter_pkg;

    // Arbiter FSM state, exported so debug/trace logic can decode it.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Default hold limit: 0 means a grant is held until done, never timed out.
    localparam int unsigned DEFAULT_HOLD_LIMIT = 0;

    // Widest supported client vector and the matching index width.
    localparam int unsigned MAX_REQUESTERS = 32;
    localparam int unsigned MAX_INDEX_W    = 5;

    // Hold counter width: ceil(log2(limit+1)), never narrower than one bit.
    function automatic int hold_cnt_width(input int unsigned limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot to binary index converter; an all-zero vector maps to index 0.
    function automatic logic [MAX_INDEX_W-1:0] onehot_to_idx(
        input logic [MAX_REQUESTERS-1:0] oh
    );
        logic [MAX_INDEX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQUESTERS; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_INDEX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/locked_rr_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping to the lowest set request when nothing sits at or above ptr.
module rr_priority_select
    import locked_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0]    ptr,
    output logic [NUM_REQUESTERS-1:0] winner_oh,
    output logic [INDEX_WIDTH-1:0]    winner_idx
);

    localparam logic [NUM_REQUESTERS-1:0] ONE = NUM_REQUESTERS'(1);

    logic [NUM_REQUESTERS-1:0] mask;
    logic [NUM_REQUESTERS-1:0] masked;
    logic [MAX_REQUESTERS-1:0] oh_wide;
    logic [MAX_INDEX_W-1:0]    idx_wide;

    // Mask off requests below ptr, isolate the lowest survivor, else fall back to the raw vector.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and infers a latch.
        mask       = '0;
        masked     = '0;
        winner_oh  = '0;
        oh_wide    = '0;
        idx_wide   = '0;
        winner_idx = '0;

        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = request & mask;

        // x & -x keeps only the lowest set bit.
        if (|masked) begin
            winner_oh = masked & (~masked + ONE);
        end else begin
            winner_oh = request & (~request + ONE);
        end

        oh_wide[NUM_REQUESTERS-1:0] = winner_oh;
        idx_wide                    = onehot_to_idx(oh_wide);
        winner_idx                  = idx_wide[INDEX_WIDTH-1:0];
    end

endmodule

// File: rtl/locked_rr_arbiter.sv
// Round-robin arbiter for one multi-cycle resource. The registered grant
// stays locked to its owner until done, or until the optional hold limit
// forces it off with a one-cycle timeout pulse.
module locked_rr_arbiter
    import locked_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned INDEX_WIDTH    = $clog2(NUM_REQUESTERS),
    parameter int unsigned HOLD_LIMIT     = DEFAULT_HOLD_LIMIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      done,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx,
    output logic                      timeout
);

    localparam int HCW = hold_cnt_width(HOLD_LIMIT);
    // Counter value on the last cycle a grant may be held.
    localparam logic [HCW-1:0] HOLD_LAST =
        (HOLD_LIMIT == 0) ? '0 : HCW'(HOLD_LIMIT - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

    arb_state_e                state_q, state_d;
    logic [INDEX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [HCW-1:0]            hold_cnt_q, hold_cnt_d;
    logic                      grant_valid_q, grant_valid_d;
    logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;
    logic [INDEX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
    logic                      timeout_q, timeout_d;

    logic [NUM_REQUESTERS-1:0] winner_oh;
    logic [INDEX_WIDTH-1:0]    winner_idx;
    logic                      any_request;
    logic                      limit_hit;

    rr_priority_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_select (
        .request    (request),
        .ptr        (ptr_q),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx)
    );

    assign any_request = |request;
    // done has priority over the limit, so the limit only matters without done.
    assign limit_hit   = (HOLD_LIMIT != 0) && (hold_cnt_q == HOLD_LAST);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_oh_q    <= '0;
            grant_idx_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_oh_q    <= grant_oh_d;
            grant_idx_q   <= grant_idx_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next state: IDLE grants on any request, BUSY releases on done or the hold limit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_request) state_d = BUSY;
            BUSY: if (done || limit_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, ptr and hold counter.
    always_comb begin
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_oh_d    = grant_oh_q;
        grant_idx_d   = grant_idx_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (any_request) begin
                    grant_valid_d = 1'b1;
                    grant_oh_d    = winner_oh;
                    grant_idx_d   = winner_idx;
                    ptr_d         = (winner_idx == LAST_IDX) ? '0
                                                             : winner_idx + INDEX_WIDTH'(1);
                end else begin
                    grant_valid_d = 1'b0;
                    grant_oh_d    = '0;
                    grant_idx_d   = '0;
                end
            end
            BUSY: begin
                if (done || limit_hit) begin
                    grant_valid_d = 1'b0;
                    grant_oh_d    = '0;
                    grant_idx_d   = '0;
                    hold_cnt_d    = '0;
                    timeout_d     = !done;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                grant_oh_d    = '0;
                grant_idx_d   = '0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    assign grant_valid = grant_valid_q;
    assign grant_oh    = grant_oh_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;

endmodule
